// File: rtl/core_sleep_pkg.sv
// Shared types and defaults for the core clock-enable (sleep) controller.
package core_sleep_pkg;

  typedef enum logic [1:0] {
    SLEEP_RUN,
    SLEEP_DRAIN,
    SLEEP_SLEEP,
    SLEEP_WAKE
  } sleep_state_e;

  localparam int unsigned IDLE_CYCLES_DEF = 4;
  localparam int unsigned WAKE_CYCLES_DEF = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/core_sleep_ctrl_if.sv
// Core-side sleep/wake signalling between the core and its clock-enable controller.
interface core_sleep_ctrl_if;

  logic sleep_req_i;
  logic core_busy_i;
  logic irq_pending_i;
  logic debug_req_i;
  logic clk_en_o;
  logic sleeping_o;
  logic wake_o;

  // Core / system side: raises requests and events, observes the enable.
  modport master (
    output sleep_req_i,
    output core_busy_i,
    output irq_pending_i,
    output debug_req_i,
    input  clk_en_o,
    input  sleeping_o,
    input  wake_o
  );

  // Controller side.
  modport slave (
    input  sleep_req_i,
    input  core_busy_i,
    input  irq_pending_i,
    input  debug_req_i,
    output clk_en_o,
    output sleeping_o,
    output wake_o
  );

endinterface

// File: rtl/core_sleep_ctrl.sv
// Clock-enable controller for the core gating cell: drains idle cycles before
// gating, and holds the enable through a settle period on wake.
module core_sleep_ctrl
  import core_sleep_pkg::*;
#(
  parameter int unsigned IdleCycles = IDLE_CYCLES_DEF,
  parameter int unsigned WakeCycles = WAKE_CYCLES_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  core_sleep_ctrl_if.slave   bus
);

  localparam int unsigned CntW = $clog2(max_u(IdleCycles, WakeCycles)) + 1;
  localparam logic [CntW-1:0] IdleLast = CntW'(IdleCycles - 1);
  localparam logic [CntW-1:0] WakeLast = CntW'(WakeCycles - 1);

  sleep_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wake_ev;
  logic            clk_en_c;
  logic            sleeping_c;
  logic            wake_c;

  assign wake_ev = bus.irq_pending_i | bus.debug_req_i;

  // Next-state, shared counter and next-state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wake_c     = 1'b0;
    clk_en_c   = 1'b1;
    sleeping_c = 1'b0;

    case (state_q)
      SLEEP_RUN: begin
        if (bus.sleep_req_i && !wake_ev) begin
          state_d = SLEEP_DRAIN;
          cnt_d   = '0;
        end
      end
      SLEEP_DRAIN: begin
        // Abort wins over counting; clock was never gated so no wake pulse.
        if (wake_ev || !bus.sleep_req_i) begin
          state_d = SLEEP_RUN;
          cnt_d   = '0;
        end else if (bus.core_busy_i) begin
          cnt_d = '0;
        end else if (cnt_q == IdleLast) begin
          state_d = SLEEP_SLEEP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      SLEEP_SLEEP: begin
        if (wake_ev) begin
          state_d = SLEEP_WAKE;
          cnt_d   = '0;
        end
      end
      SLEEP_WAKE: begin
        if (cnt_q == WakeLast) begin
          state_d = SLEEP_RUN;
          cnt_d   = '0;
          wake_c  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = SLEEP_RUN;
        cnt_d   = '0;
      end
    endcase

    clk_en_c   = (state_d != SLEEP_SLEEP);
    sleeping_c = (state_d == SLEEP_SLEEP);
  end

  // State, counter and registered outputs; reset leaves the core clock running.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= SLEEP_RUN;
      cnt_q          <= '0;
      bus.clk_en_o   <= 1'b1;
      bus.sleeping_o <= 1'b0;
      bus.wake_o     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bus.clk_en_o   <= clk_en_c;
      bus.sleeping_o <= sleeping_c;
      bus.wake_o     <= wake_c;
    end
  end

endmodule

// File: tb/tb_core_sleep_ctrl.sv
// Directed plus randomized bench for core_sleep_ctrl against a cycle-level
// behavioural model of the sleep/wake protocol.
module tb_core_sleep_ctrl;

  localparam int unsigned IDLE = 4;
  localparam int unsigned WAKE = 2;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  core_sleep_ctrl_if bus ();

  core_sleep_ctrl #(.IdleCycles(IDLE), .WakeCycles(WAKE)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: gated flag, consecutive idle cycles seen while draining, remaining
  // settle edges after a wake, and the resume pulse.
  bit m_gated, m_drain, m_pulse;
  int m_idle, m_wake_left;

  task automatic model_reset();
    m_gated = 0; m_drain = 0; m_pulse = 0; m_idle = 0; m_wake_left = 0;
  endtask

  task automatic model_edge();
    bit ev;
    ev = bus.irq_pending_i | bus.debug_req_i;
    m_pulse = 0;
    if (rst) begin
      model_reset();
    end else if (m_wake_left > 0) begin
      m_wake_left--;
      if (m_wake_left == 0) m_pulse = 1;
    end else if (m_gated) begin
      if (ev) begin
        m_gated = 0;
        m_wake_left = WAKE;
      end
    end else if (m_drain) begin
      if (ev || !bus.sleep_req_i) m_drain = 0;
      else if (bus.core_busy_i) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == IDLE) begin
          m_gated = 1;
          m_drain = 0;
        end
      end
    end else if (bus.sleep_req_i && !ev) begin
      m_drain = 1;
      m_idle = 0;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".clk_en"},   bus.clk_en_o,   logic'(!m_gated));
    chk({tag, ".sleeping"}, bus.sleeping_o, logic'(m_gated));
    chk({tag, ".wake"},     bus.wake_o,     logic'(m_pulse));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk_model(tag);
  endtask

  task automatic set_in(input logic req, input logic busy, input logic irq, input logic dbg);
    bus.sleep_req_i   = req;
    bus.core_busy_i   = busy;
    bus.irq_pending_i = irq;
    bus.debug_req_i   = dbg;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0);
    model_reset();
    #12;
    chk("reset.clk_en", bus.clk_en_o, 1'b1);
    chk("reset.sleeping", bus.sleeping_o, 1'b0);
    chk("reset.wake", bus.wake_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // 1: reach SLEEP, then async reset off-edge.
    set_in(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step("t1.drain");
    chk("t1.asleep", bus.sleeping_o, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t1.async_clk_en", bus.clk_en_o, 1'b1);
    chk("t1.async_sleeping", bus.sleeping_o, 1'b0);
    #3;
    rst = 1'b0;
    set_in(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("t1.run");

    // 2: plain sleep entry latency.
    set_in(1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step("t2.edge");
      chk("t2.en_high", bus.clk_en_o, 1'b1);
    end
    step("t2.edge5");
    chk("t2.en_low", bus.clk_en_o, 1'b0);
    chk("t2.sleeping", bus.sleeping_o, 1'b1);

    // 4: wake by irq; settle then one-cycle resume pulse.
    for (int i = 0; i < 5; i++) step("t4.hold");
    set_in(0, 0, 1, 0);
    step("t4.k");
    chk("t4.en_at_k", bus.clk_en_o, 1'b1);
    set_in(0, 0, 0, 0);
    step("t4.k1");
    chk("t4.no_wake_k1", bus.wake_o, 1'b0);
    step("t4.k2");
    chk("t4.wake_k2", bus.wake_o, 1'b1);
    step("t4.k3");
    chk("t4.wake_gone", bus.wake_o, 1'b0);

    // 3: busy on edge 3 restarts the idle count.
    set_in(1, 0, 0, 0);
    step("t3.e1");
    step("t3.e2");
    set_in(1, 1, 0, 0);
    step("t3.e3");
    set_in(1, 0, 0, 0);
    for (int i = 4; i <= 6; i++) begin
      step("t3.edge");
      chk("t3.en_high", bus.clk_en_o, 1'b1);
    end
    step("t3.e7");
    chk("t3.en_low", bus.clk_en_o, 1'b0);
    set_in(0, 0, 0, 1);
    step("t3.dbg_wake");
    set_in(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("t3.settle");

    // 5: debug on the final idle edge aborts the drain.
    set_in(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("t5.drain");
    set_in(1, 0, 0, 1);
    step("t5.abort");
    chk("t5.en_kept", bus.clk_en_o, 1'b1);
    set_in(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step("t5.after");
      chk("t5.no_wake", bus.wake_o, 1'b0);
      chk("t5.en", bus.clk_en_o, 1'b1);
    end

    // 6: pending irq blocks sleep; dropping it enters drain next edge.
    set_in(1, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step("t6.blocked");
      chk("t6.en", bus.clk_en_o, 1'b1);
    end
    set_in(1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step("t6.drain");
    chk("t6.en_before", bus.clk_en_o, 1'b1);
    step("t6.gate");
    chk("t6.en_low", bus.clk_en_o, 1'b0);
    set_in(0, 0, 1, 0);
    step("t6.wake");
    set_in(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("t6.settle");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      set_in(logic'($urandom_range(0, 99) < 85), logic'($urandom_range(0, 99) < 25),
             logic'($urandom_range(0, 99) < 5),  logic'($urandom_range(0, 99) < 3));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_sleep_ctrl.md
Name: core_sleep_ctrl

Overview:
Clock-enable controller that sits directly upstream of the core's clock gating cell and drives its en_i.
- Runs on the free-running (ungated) clock.
- Accepts a sleep request from the core (WFI), waits for a programmable number of consecutive idle cycles, then drops the enable.
- Restores the enable on an interrupt or debug wake event, with a settle period before the core is told it has resumed.
- clk_en_o is registered, so it changes only at clk_i rising edges and is stable when the gating cell latches it on the falling edge.

Parameters:
- IdleCycles, 4: consecutive non-busy cycles required in DRAIN before gating. Legal range is 1 or more.
- WakeCycles, 2: cycles the enable is held high in WAKE before returning to RUN. Legal range is 1 or more.
- CntW, $clog2(max(IdleCycles,WakeCycles))+1: width of the shared counter. Derived; do not override.

Ports:
- clk_i, input, 1: free-running clock, never gated.
- rst_i, input, 1: reset, asynchronous, active-high.
- sleep_req_i, input, 1: core requests sleep (WFI). Level; the core holds it while waiting.
- core_busy_i, input, 1: core has outstanding bus/LSU/pipeline activity.
- irq_pending_i, input, 1: any enabled interrupt pending. Synchronous to clk_i.
- debug_req_i, input, 1: debug halt request. Synchronous to clk_i.
- clk_en_o, output, 1: enable to the clock gating cell.
- sleeping_o, output, 1: core clock is gated.
- wake_o, output, 1: single-cycle pulse when the core resumes in RUN after a sleep.

Behaviour:
- wake_ev = irq_pending_i | debug_req_i.
- Reset (rst_i high, asynchronous): state RUN, cnt=0, clk_en_o=1, sleeping_o=0, wake_o=0.
- States are RUN, DRAIN, SLEEP and WAKE. All outputs are registered, decoded from next-state.
- RUN:
  - clk_en_o=1.
  - If sleep_req_i & !wake_ev: go to DRAIN, cnt<=0.
  - Otherwise stay in RUN.
- DRAIN:
  - clk_en_o=1.
  - If wake_ev or !sleep_req_i: go to RUN, cnt<=0. No wake_o pulse, because the clock was never gated. This check has priority over counting.
  - Else if core_busy_i: cnt<=0 and stay in DRAIN.
  - Else if cnt==IdleCycles-1: go to SLEEP.
  - Else: cnt<=cnt+1.
- SLEEP:
  - clk_en_o=0, sleeping_o=1.
  - sleep_req_i and core_busy_i are ignored; they are frozen because the core clock is off.
  - If wake_ev: go to WAKE, cnt<=0.
- WAKE:
  - clk_en_o=1, sleeping_o=0.
  - wake_ev is ignored.
  - cnt increments each cycle. When cnt==WakeCycles-1, go to RUN and assert wake_o for exactly that one following cycle.
- Sleep latency: sleep_req_i is first sampled high at edge 1 with busy low throughout. clk_en_o falls at edge 1+IdleCycles.
- Wake latency: wake_ev is sampled at edge k in SLEEP. clk_en_o rises at edge k; wake_o is high in the cycle after edge k+WakeCycles.
- Simultaneous events:
  - sleep_req_i and wake_ev high together in RUN: stay in RUN.
  - wake_ev on the same cycle as the final idle count in DRAIN: go to RUN; the enable never drops.
  - core_busy_i rising mid-DRAIN restarts the idle count from 0.
- Reset mid-operation, from any state: immediate RUN with clk_en_o=1. The core clock is always running out of reset.
- Unreachable state encodings: next state is RUN, clk_en_o=1 (fail-safe enable).
- cnt never wraps. It is bounded by the comparisons above, and width CntW covers both limits.

Decomposition:
- Package core_sleep_pkg holds:
  - typedef enum logic [1:0] sleep_state_e {SLEEP_RUN, SLEEP_DRAIN, SLEEP_SLEEP, SLEEP_WAKE};
  - default constants for IdleCycles and WakeCycles.
- No sub-module: FSM plus one shared counter in a single module.
- The gating cell is instantiated by the parent, with clk_en_o wired to its en_i. It is not instantiated inside this block.

Test Plan:
1. Reset asserted mid-SLEEP, async, not aligned to a clock edge -> clk_en_o=1 and sleeping_o=0 immediately, state RUN; release reset and hold sleep_req_i=0 -> stays in RUN.
2. IdleCycles=4, sleep_req_i=1 at edge 1, busy=0 -> clk_en_o=1 through edge 4, clk_en_o=0 and sleeping_o=1 from edge 5.
3. Same as 2 but core_busy_i=1 on edge 3 only -> idle count restarts, clk_en_o falls at edge 7.
4. In SLEEP, irq_pending_i=1 at edge 20, WakeCycles=2 -> clk_en_o=1 at edge 20, wake_o high for exactly the cycle after edge 22, then 0.
5. In DRAIN, debug_req_i=1 on the cycle cnt==IdleCycles-1 -> state RUN, clk_en_o never drops, wake_o stays 0.
6. In RUN, sleep_req_i=1 with irq_pending_i=1 held -> remains in RUN indefinitely; drop irq -> DRAIN entered next edge.
